// File: rtl/button_conditioner.sv
// Four-channel push-button conditioner: synchronize, debounce,
// and generate press / auto-repeat strobes per button.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_in,
  input  logic [3:0] rep_en,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE)
                      ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX);

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST =
    RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST =
    RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DELAY,
    REPEAT
  } state_t;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_pulse;
    logic [DW-1:0] r_dcnt;
    logic [RW-1:0] r_rcnt;
    state_t        r_state;

    logic          w_diff;
    logic          w_flip;
    logic          w_rise;
    logic          w_fall;
    logic          w_pulse_nxt;
    logic [RW-1:0] w_rcnt_nxt;
    state_t        w_state_nxt;

    assign w_diff = r_s2 ^ r_level;
    assign w_flip = w_diff && (r_dcnt == DB_LAST);
    assign w_rise = w_flip && r_s2;
    assign w_fall = w_flip && !r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_level <= 1'b0;
        r_dcnt  <= '0;
      end else begin
        r_s1 <= btn_in[g];
        r_s2 <= r_s1;
        if (!w_diff) begin
          r_dcnt <= '0;
        end else if (w_flip) begin
          r_level <= r_s2;
          r_dcnt  <= '0;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_rcnt  <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_rcnt  <= w_rcnt_nxt;
        r_pulse <= w_pulse_nxt;
      end
    end

    // A falling level overrides any repeat strobe due now.
    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_pulse_nxt = 1'b0;
      if (w_fall) begin
        w_state_nxt = IDLE;
        w_rcnt_nxt  = '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_rise) begin
              w_state_nxt = WAIT_DELAY;
              w_rcnt_nxt  = '0;
              w_pulse_nxt = 1'b1;
            end
          end
          WAIT_DELAY: begin
            if (!rep_en[g]) begin
              w_rcnt_nxt = '0;
            end else if (r_rcnt == RD_LAST) begin
              w_state_nxt = REPEAT;
              w_rcnt_nxt  = '0;
              w_pulse_nxt = 1'b1;
            end else begin
              w_rcnt_nxt = r_rcnt + RW'(1);
            end
          end
          REPEAT: begin
            if (!rep_en[g]) begin
              w_state_nxt = WAIT_DELAY;
              w_rcnt_nxt  = '0;
            end else if (r_rcnt == RR_LAST) begin
              w_rcnt_nxt  = '0;
              w_pulse_nxt = 1'b1;
            end else begin
              w_rcnt_nxt = r_rcnt + RW'(1);
            end
          end
          default: begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = '0;
          end
        endcase
      end
    end

    assign btn_level[g] = r_level;
    assign btn_pulse[g] = r_pulse;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal
// expectations plus random stimulus against a behavioural model.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] rep_en;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] pl [0:99];
  logic [3:0] lv [0:99];

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .rep_en   (rep_en),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: run lengths and ages since the last strobe.
  logic [3:0] m_s1 = '0;
  logic [3:0] m_s2 = '0;
  logic [3:0] m_lvl = '0;
  logic [3:0] m_pls = '0;
  bit         m_act [4];
  int         m_run [4];
  int         m_age [4];
  int         m_tgt [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      m_pls = '0;
      for (int b = 0; b < 4; b++) begin
        m_act[b] = 1'b0;
        m_run[b] = 0;
        m_age[b] = 0;
        m_tgt[b] = RD;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        logic s;
        logic rose;
        logic fell;
        s    = m_s2[b];
        rose = 1'b0;
        fell = 1'b0;
        if (s != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_lvl[b] = s;
            m_run[b] = 0;
            rose = s;
            fell = !s;
          end
        end else begin
          m_run[b] = 0;
        end
        m_pls[b] = 1'b0;
        if (rose) begin
          m_pls[b] = 1'b1;
          m_act[b] = 1'b1;
          m_age[b] = 0;
          m_tgt[b] = RD;
        end else if (fell) begin
          m_act[b] = 1'b0;
        end else if (m_act[b]) begin
          if (!rep_en[b]) begin
            m_age[b] = 0;
            m_tgt[b] = RD;
          end else begin
            m_age[b]++;
            if (m_age[b] == m_tgt[b]) begin
              m_pls[b] = 1'b1;
              m_age[b] = 0;
              m_tgt[b] = RR;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  end

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  // One clock: outputs are compared to the model mid-cycle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("model_level", btn_level, m_lvl);
    chk("model_pulse", btn_pulse, m_pls);
  endtask

  task automatic rec(input int k);
    step();
    pl[k] = btn_pulse;
    lv[k] = btn_level;
  endtask

  task automatic chk_pulses(input string nm, input int b,
                            input int t, input int lo,
                            input int hi, input int offs[$]);
    for (int k = lo; k <= hi; k++) begin
      logic e;
      e = 1'b0;
      foreach (offs[i]) if (offs[i] == k - t) e = 1'b1;
      chk($sformatf("%s_b%0d_t%0d", nm, b, k - t),
          {3'b0, pl[k][b]}, {3'b0, e});
    end
  endtask

  initial begin
    logic [3:0] acc;
    rst_n  = 1'b0;
    btn_in = 4'hF;
    rep_en = 4'h0;

    // Held through reset, then released: one press per bit.
    repeat (3) step();
    chk("rst_level", btn_level, 4'h0);
    chk("rst_pulse", btn_pulse, 4'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) rec(k);
    chk("rel_lvl5", lv[5], 4'h0);
    chk("rel_lvl6", lv[6], 4'hF);
    chk("rel_pls6", pl[6], 4'hF);
    chk("rel_pls7", pl[7], 4'h0);
    acc = '0;
    for (int k = 7; k <= 25; k++) acc |= pl[k];
    chk("rel_norep", acc, 4'h0);
    btn_in = 4'h0;
    repeat (12) step();
    chk("rel_fall", btn_level, 4'h0);

    // Bounce: 3 high / 1 low never reaches the debounce count.
    acc = '0;
    for (int r = 0; r < 4; r++) begin
      btn_in[0] = 1'b1;
      repeat (3) begin
        step();
        acc |= btn_level | btn_pulse;
      end
      btn_in[0] = 1'b0;
      step();
      acc |= btn_level | btn_pulse;
    end
    chk("bounce_quiet", acc, 4'h0);
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++) rec(k);
    chk("bounce_lvl5", lv[5], 4'h0);
    chk("bounce_lvl6", lv[6], 4'h1);
    chk_pulses("bounce", 0, 6, 1, 20, '{0});
    btn_in = 4'h0;
    repeat (12) step();

    // Auto-repeat; raw release lands the fall on a due strobe.
    rep_en = 4'b0010;
    btn_in = 4'b0010;
    for (int k = 1; k <= 50; k++) begin
      rec(k);
      if (k == 31) btn_in = 4'h0;
    end
    chk_pulses("rep", 1, 6, 1, 50,
               '{0, 10, 13, 16, 19, 22, 25, 28});
    chk("rep_lvl36", lv[36], 4'b0010);
    chk("rep_lvl37", lv[37], 4'b0000);
    repeat (10) step();

    // Enable dropped t+12..t+14 restarts the full delay.
    rep_en = 4'b0100;
    btn_in = 4'b0100;
    for (int k = 1; k <= 40; k++) begin
      rec(k);
      if (k == 18) rep_en = 4'b0000;
      if (k == 21) rep_en = 4'b0100;
      if (k == 33) btn_in = 4'h0;
    end
    chk_pulses("ena", 2, 6, 1, 40, '{0, 10, 25, 28, 31});
    repeat (10) step();

    // Two channels two cycles apart, released together.
    rep_en = 4'b1001;
    btn_in = 4'b1000;
    for (int k = 1; k <= 30; k++) begin
      rec(k);
      if (k == 2) btn_in = 4'b1001;
      if (k == 18) btn_in = 4'b0000;
    end
    chk_pulses("ind", 3, 6, 1, 30, '{0, 10, 13, 16});
    chk_pulses("ind", 0, 8, 1, 30, '{0, 10, 13});
    chk("ind_lvl23", lv[23], 4'b1001);
    chk("ind_lvl24", lv[24], 4'b0000);
    repeat (10) step();

    // Reset mid-repeat clears at once; held button re-presses.
    rep_en = 4'b0010;
    btn_in = 4'b0010;
    repeat (20) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", btn_level, 4'h0);
    chk("arst_pulse", btn_pulse, 4'h0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) rec(k);
    acc = '0;
    for (int k = 1; k <= 5; k++) acc |= pl[k];
    chk("arst_quiet", acc, 4'h0);
    chk("arst_press", pl[6], 4'b0010);
    btn_in = 4'h0;
    rep_en = 4'h0;
    repeat (12) step();

    // Random phase, checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 9) == 0) btn_in[b] = ~btn_in[b];
        if ($urandom_range(0, 49) == 0) rep_en[b] = ~rep_en[b];
      end
      if ($urandom_range(0, 999) == 0) #2 rst_n = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable synchronized cycles required before the debounced level changes; legal range >= 2.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50000000: cycles from the press pulse to the first auto-repeat pulse; legal range >= 2.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 12500000: cycles between successive auto-repeat pulses; legal range >= 2.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_in  input  4  raw asynchronous push-buttons; bit order [3:0] = {btnU, btnD, btnL, btnR}.
REQ-007 rep_en  input  4  per-button auto-repeat enable, synchronous to clk.
REQ-008 btn_level  output  4  debounced button level, registered.
REQ-009 btn_pulse  output  4  single-cycle strobe on each debounced press and on each auto-repeat, registered; it drives the time-set and alarm-set increment inputs in place of raw levels.

Function
REQ-010 Each bit SHALL be processed by an independent, identical channel, with no interaction between channels.
REQ-011 Each btn_in bit SHALL pass through a 2-flop synchronizer, output s; no other logic SHALL see btn_in.
REQ-012 The debounce counter SHALL increment each cycle s != btn_level, and SHALL clear to 0 in any cycle s == btn_level.
REQ-013 When s != btn_level and the counter equals DEBOUNCE_CYCLES-1, btn_level SHALL take s and the counter SHALL clear, so btn_level changes exactly DEBOUNCE_CYCLES cycles after s first differs.
REQ-014 Raw-to-level latency for a clean edge SHALL be 2+DEBOUNCE_CYCLES cycles; any bounce shorter than DEBOUNCE_CYCLES SHALL restart the count and produce no level change.
REQ-015 Each channel SHALL run an FSM with states IDLE, WAIT_DELAY and REPEAT.
REQ-016 IDLE -> WAIT_DELAY SHALL occur when btn_level rises, and btn_pulse SHALL be high in the first cycle btn_level reads 1 (press pulse).
REQ-017 In WAIT_DELAY with rep_en=1, the repeat counter SHALL count from the press pulse; btn_pulse SHALL assert exactly REPEAT_DELAY cycles after the press pulse, followed by a move to REPEAT and a counter clear.
REQ-018 In REPEAT with rep_en=1, btn_pulse SHALL assert every REPEAT_RATE cycles after the previous pulse.
REQ-019 When rep_en=0 in WAIT_DELAY or REPEAT, the repeat counter SHALL hold at 0 and the FSM SHALL go to WAIT_DELAY; when rep_en is re-asserted, the full REPEAT_DELAY SHALL elapse before the next pulse.
REQ-020 When btn_level falls, the FSM SHALL move from any state to IDLE, clear the repeat counter and produce no pulse; a falling level and a due repeat pulse in the same cycle SHALL resolve to no pulse.
REQ-021 btn_pulse SHALL never be high for two consecutive cycles on one bit.
REQ-022 Counter widths SHALL be $clog2 of the respective parameter, and counters SHALL never wrap.

Reset
REQ-023 While rst_n=0, btn_level, btn_pulse, the synchronizers, all counters and all FSMs (IDLE) SHALL be 0 immediately, independent of clk.
REQ-024 On rst_n deassertion with a button already held, the held button SHALL be treated as a new press: level rises after 2+DEBOUNCE_CYCLES cycles with one press pulse.
REQ-025 Reset asserted mid-repeat SHALL abort the channel with no further pulses until a new debounced press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-026 Reset: btn_in=4'hF while rst_n=0 -> btn_level=0 and btn_pulse=0 throughout; after release, btn_level=4'hF at cycle 6, one pulse per bit, then nothing with rep_en=0.
REQ-027 Bounce: btn_in[0] toggles high 3 cycles / low 1 cycle repeatedly, then stays high -> no level change during toggling; btn_level[0] rises 6 cycles after the final rising edge, with exactly one pulse.
REQ-028 Auto-repeat: rep_en[1]=1, btn_in[1] held 30 cycles past level rise at cycle t -> pulses at t, t+10, t+13, t+16, ..., t+28, and none after release.
REQ-029 Enable toggle: rep_en[2] dropped at t+12 and raised at t+15 -> pulses at t and t+10 only, then the next at t+25.
REQ-030 Independence and release: btn_in[3] and btn_in[0] pressed 2 cycles apart -> pulses 2 cycles apart; after release, levels fall 6 cycles later with no pulse, including when a repeat pulse falls due in that cycle.
